// File: rtl/led_pattern_controller.sv
// led_pattern_controller: debounces the four board switches and turns their release events
// into mode/speed/pause/restart control of a ticked LED pattern sequencer.
module led_pattern_controller #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int TICK_BASE      = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [1:0] o_Mode,
    output logic [1:0] o_Speed,
    output logic       o_Paused
);
    localparam int DW = $clog2(DEBOUNCE_LIMIT + 1);
    localparam int TW = $clog2(8 * TICK_BASE);

    typedef enum logic [1:0] {OFF, STATIC, BLINK, CHASE} mode_t;

    logic [3:0]    sw_raw;
    logic [DW-1:0] db_cnt_q [4];
    logic [DW-1:0] db_cnt_d [4];
    logic [3:0]    db_q, db_d, db_prev_q, rel;
    mode_t         mode_q, mode_d;
    logic [1:0]    speed_q, speed_d;
    logic          paused_q, paused_d;
    logic [3:0]    pat_q, pat_d;
    logic [TW-1:0] tcnt_q, tcnt_d, period_m1;
    logic          tick;

    function automatic logic [3:0] entry(input mode_t m);
        return (m == OFF) ? 4'h0 : (m == CHASE) ? 4'h1 : 4'hF;
    endfunction

    assign sw_raw    = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
    assign rel       = db_prev_q & ~db_q;
    assign period_m1 = (TW'(TICK_BASE) << speed_q) - TW'(1);
    assign tick      = !paused_q && (tcnt_q == period_m1);

    always_comb begin
        db_d = db_q;
        for (int k = 0; k < 4; k++) begin
            db_cnt_d[k] = '0;
            if (sw_raw[k] != db_q[k]) begin
                if (db_cnt_q[k] == DW'(DEBOUNCE_LIMIT - 1)) db_d[k] = sw_raw[k];
                else db_cnt_d[k] = db_cnt_q[k] + DW'(1);
            end
        end
    end

    // Events are mutually exclusive by priority; any event overrides a same-cycle tick.
    always_comb begin
        mode_d   = mode_q;
        speed_d  = speed_q;
        paused_d = paused_q;
        pat_d    = pat_q;
        tcnt_d   = paused_q ? tcnt_q : tick ? '0 : tcnt_q + TW'(1);
        if (tick && mode_q == BLINK) pat_d = ~pat_q;
        if (tick && mode_q == CHASE) pat_d = {pat_q[2:0], pat_q[3]};
        if (rel[3]) begin
            pat_d    = entry(mode_q);
            tcnt_d   = '0;
            paused_d = 1'b0;
        end else if (rel[0]) begin
            mode_d   = mode_t'(mode_q + 2'd1);
            paused_d = 1'b0;
            tcnt_d   = '0;
            pat_d    = entry(mode_d);
        end else if (rel[1]) begin
            speed_d = speed_q + 2'd1;
            tcnt_d  = '0;
            pat_d   = pat_q;
        end else if (rel[2]) begin
            paused_d = ~paused_q;
            tcnt_d   = tcnt_q;
            pat_d    = pat_q;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            for (int k = 0; k < 4; k++) db_cnt_q[k] <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            mode_q    <= OFF;
            speed_q   <= '0;
            paused_q  <= 1'b0;
            pat_q     <= '0;
            tcnt_q    <= '0;
        end else begin
            for (int k = 0; k < 4; k++) db_cnt_q[k] <= db_cnt_d[k];
            db_q      <= db_d;
            db_prev_q <= db_q;
            mode_q    <= mode_d;
            speed_q   <= speed_d;
            paused_q  <= paused_d;
            pat_q     <= pat_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign {o_LED_4, o_LED_3, o_LED_2, o_LED_1} = pat_q;
    assign o_Mode   = mode_q;
    assign o_Speed  = speed_q;
    assign o_Paused = paused_q;
endmodule
